audio_click_scheduler: RTL and testbench
========================================

Name: audio_click_scheduler

Overview:
Sequences the audio codec output path for the metronome. A fractional phase accumulator converts a BPM value into beat events. On each beat the block streams a fixed-length square-wave click burst into the Audio_Controller write port, and writes silence between clicks. Beat 0 of each bar is accented with double pitch. Sits between the system tempo logic and Audio_Controller, and replaces the free-running square_wave_osc feed.

Parameters:
CLK_HZ, 50000000, clock frequency; beat modulus is CLK_HZ*60.
SAMPLE_W, 32, audio sample width.
CLICK_SAMPLES, 2400, samples per click burst (50 ms at 48 kHz).
HALF_PER, 24, samples per half-cycle of a normal click (1 kHz at 48 kHz).
AMPLITUDE, 32'h1000_0000, positive click level; negative level is its two's complement.
BEATS_PER_BAR, 4, bar length; beat_index wraps at this value.

Ports:
CLOCK_50  in  1  system clock.
iRST_N  in  1  synchronous active-low reset.
enable  in  1  metronome run; low means silent with the timebase cleared.
bpm  in  9  tempo, clamped internally to the range 30..300.
audio_out_allowed  in  1  Audio_Controller output FIFO has space.
write_audio_out  out  1  sample write strobe to Audio_Controller.
left_channel_audio_out  out  SAMPLE_W  sample data.
right_channel_audio_out  out  SAMPLE_W  identical to left.
beat_pulse  out  1  one-cycle strobe per beat (drives LEDG and display).
beat_index  out  2  current beat within the bar.
busy  out  1  high while a click burst is in progress.

Behaviour:
- Reset (iRST_N=0 at a clock edge): all outputs 0, accumulator 0, FSM IDLE, sample and half-period counters 0. Reset mid-burst aborts the burst; the first sample after reset is 0.
- Timebase:
  - Accumulator acc is 32 bits. Each cycle with enable=1: if acc + bpm_c >= CLK_HZ*60, then acc <= acc + bpm_c - CLK_HZ*60 and beat_pulse <= 1; else acc <= acc + bpm_c.
  - bpm_c is the clamped bpm. Values below 30 become 30; values above 300 become 300.
  - bpm changes take effect on the next cycle; the phase is not reset.
- enable=0: acc is held at CLK_HZ*60-1, FSM goes to IDLE, beat_index is 0, and outputs are silent. The first enabled cycle therefore produces beat_pulse on the next edge, i.e. an immediate beat with beat_index 0.
- beat_index: advances on each beat_pulse except the first after enable; wraps BEATS_PER_BAR-1 -> 0. It is updated in the same cycle as beat_pulse.
- FSM states:
  - IDLE: sample = 0.
    - beat_pulse -> ARM.
  - ARM (one cycle): load sample_cnt = CLICK_SAMPLES and half_cnt = period. Period is HALF_PER/2 when beat_index=0, else HALF_PER. Set sample = +AMPLITUDE and busy=1.
    - -> CLICK.
  - CLICK: on each accepted write:
    - sample_cnt decrements; half_cnt decrements.
    - When half_cnt reaches 1, reload it and negate sample.
    - When the last sample (sample_cnt=1) is written -> IDLE, with sample = 0 and busy = 0 on the next cycle.
  - A beat_pulse arriving in CLICK or ARM goes to ARM, restarting the burst with the new beat's pitch.
- Write handshake:
  - write_audio_out = enable & audio_out_allowed & iRST_N, combinational.
  - In IDLE, zeros stream whenever allowed, keeping the codec fed.
  - Sample data is registered and stable during the write cycle; it updates on the edge following an accepted write.
  - No writes occur while audio_out_allowed=0; counters hold.
- Latency: beat_pulse -> first click sample presented = 2 cycles, then written on the next allowed cycle.
- Width rules:
  - sample_cnt is wide enough for CLICK_SAMPLES.
  - The modulus compare is done at 33 bits to avoid overflow.

Decomposition:
- Package metronome_pkg holds:
  - BPM_MIN=30 and BPM_MAX=300.
  - The state enum {IDLE, ARM, CLICK}.
  - The function beat_modulus(CLK_HZ).
  - The function clamp_bpm.
- One sub-module, beat_timebase, contains the accumulator, clamp, beat_pulse and beat_index logic. The parent holds the FSM and sample generator.

Test Plan:
All scenarios use CLK_HZ=1000 (modulus 60000), CLICK_SAMPLES=8, HALF_PER=2, AMPLITUDE=100.
1. Reset, then enable=1, bpm=120, audio_out_allowed=1 held -> beat_pulse at cycle 1 and every 500 cycles thereafter; beat_index sequence 0,1,2,3,0.
2. Accent burst (beat_index 0) -> 8 written samples +100,-100,+100,-100,... (half-period 1), then zeros; non-accent burst -> +100,+100,-100,-100,+100,+100,-100,-100.
3. Toggle audio_out_allowed every other cycle during a click -> exactly 8 click writes, no sample skipped or repeated, burst takes 16 cycles.
4. bpm=10 then bpm=400 -> beat spacing 2000 cycles and then 200 cycles (clamped to 30 and 300).
5. iRST_N=0 for one cycle at click sample 4 -> next cycle all outputs 0 and busy=0; after release with enable=1, immediate beat_pulse with beat_index=0.
6. bpm=300, CLICK_SAMPLES=300, allowed=1 -> each beat restarts the burst via ARM; busy never drops; beat_index still advances each beat.

Source files
------------

// File: rtl/metronome_pkg.sv
// Shared types and helpers for the metronome audio click path.
package metronome_pkg;

    localparam int unsigned BPM_W   = 9;
    localparam int unsigned BPM_MIN = 30;
    localparam int unsigned BPM_MAX = 300;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CLICK = 2'd2
    } click_state_e;

    // One beat elapses when the accumulated bpm reaches clk_hz*60.
    function automatic logic [32:0] beat_modulus(input int unsigned clk_hz);
        return 33'(clk_hz) * 33'd60;
    endfunction

    function automatic logic [BPM_W-1:0] clamp_bpm(input logic [BPM_W-1:0] bpm);
        logic [BPM_W-1:0] res;
        res = bpm;
        if (bpm < BPM_W'(BPM_MIN)) begin
            res = BPM_W'(BPM_MIN);
        end else if (bpm > BPM_W'(BPM_MAX)) begin
            res = BPM_W'(BPM_MAX);
        end
        return res;
    endfunction

endpackage

// File: rtl/beat_timebase.sv
// Fractional phase accumulator turning a BPM value into beat strobes and a bar position.
module beat_timebase
    import metronome_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned BEATS_PER_BAR = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic [BPM_W-1:0] bpm_i,
    output logic             beat_pulse_o,
    output logic [1:0]       beat_index_o
);

    localparam logic [32:0] MODULUS  = beat_modulus(CLK_HZ);
    localparam logic [31:0] ACC_HOLD = 32'(MODULUS - 33'd1);

    logic [31:0]      acc_q, acc_d;
    logic             fresh_q, fresh_d;
    logic             beat_q, beat_d;
    logic [1:0]       idx_q, idx_d;
    logic [BPM_W-1:0] bpm_c;
    logic [32:0]      sum_c;

    assign bpm_c = clamp_bpm(bpm_i);
    assign sum_c = {1'b0, acc_q} + 33'(bpm_c);

    // fresh_q marks that the next enabled cycle is the immediate first beat, which does not advance the bar.
    always_comb begin
        acc_d   = acc_q;
        fresh_d = fresh_q;
        beat_d  = 1'b0;
        idx_d   = idx_q;
        if (!enable_i) begin
            acc_d   = ACC_HOLD;
            fresh_d = 1'b1;
            idx_d   = '0;
        end else if (fresh_q) begin
            acc_d   = 32'(bpm_c) - 32'd1;
            fresh_d = 1'b0;
            beat_d  = 1'b1;
            idx_d   = '0;
        end else if (sum_c >= MODULUS) begin
            acc_d  = 32'(sum_c - MODULUS);
            beat_d = 1'b1;
            idx_d  = (idx_q == 2'(BEATS_PER_BAR - 1)) ? 2'd0 : idx_q + 2'd1;
        end else begin
            acc_d = sum_c[31:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q   <= '0;
            fresh_q <= 1'b1;
            beat_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            fresh_q <= fresh_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
        end
    end

    assign beat_pulse_o = beat_q;
    assign beat_index_o = idx_q;

endmodule

// File: rtl/audio_click_scheduler.sv
// Metronome audio feed: streams a square-wave click burst per beat into the codec, silence otherwise.
module audio_click_scheduler
    import metronome_pkg::*;
#(
    parameter int unsigned         CLK_HZ        = 50000000,
    parameter int unsigned         SAMPLE_W      = 32,
    parameter int unsigned         CLICK_SAMPLES = 2400,
    parameter int unsigned         HALF_PER      = 24,
    parameter logic [SAMPLE_W-1:0] AMPLITUDE     = SAMPLE_W'(32'h1000_0000),
    parameter int unsigned         BEATS_PER_BAR = 4
) (
    input  logic                CLOCK_50,
    input  logic                iRST_N,
    input  logic                enable,
    input  logic [8:0]          bpm,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [SAMPLE_W-1:0] left_channel_audio_out,
    output logic [SAMPLE_W-1:0] right_channel_audio_out,
    output logic                beat_pulse,
    output logic [1:0]          beat_index,
    output logic                busy
);

    localparam int unsigned CNT_W  = $clog2(CLICK_SAMPLES + 1);
    localparam int unsigned HCNT_W = $clog2(HALF_PER + 1);

    click_state_e        state_q, state_d;
    logic [CNT_W-1:0]    scnt_q, scnt_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [HCNT_W-1:0]   per_q, per_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                busy_q, busy_d;

    beat_timebase #(
        .CLK_HZ        (CLK_HZ),
        .BEATS_PER_BAR (BEATS_PER_BAR)
    ) u_timebase (
        .clk_i        (CLOCK_50),
        .rst_n_i      (iRST_N),
        .enable_i     (enable),
        .bpm_i        (bpm),
        .beat_pulse_o (beat_pulse),
        .beat_index_o (beat_index)
    );

    // The codec is fed every allowed cycle; zeros outside a burst keep it from underrunning.
    assign write_audio_out = enable & audio_out_allowed & iRST_N;

    // A new beat always restarts the burst, even mid-click, so the pitch follows the latest beat.
    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        hcnt_d   = hcnt_q;
        per_d    = per_q;
        sample_d = sample_q;
        busy_d   = busy_q;
        if (!enable) begin
            state_d  = IDLE;
            sample_d = '0;
            busy_d   = 1'b0;
        end else if (beat_pulse) begin
            state_d = ARM;
        end else begin
            case (state_q)
                IDLE: begin
                    sample_d = '0;
                    busy_d   = 1'b0;
                end
                ARM: begin
                    per_d    = (beat_index == 2'd0) ? HCNT_W'(HALF_PER / 2) : HCNT_W'(HALF_PER);
                    hcnt_d   = per_d;
                    scnt_d   = CNT_W'(CLICK_SAMPLES);
                    sample_d = AMPLITUDE;
                    busy_d   = 1'b1;
                    state_d  = CLICK;
                end
                CLICK: begin
                    if (write_audio_out) begin
                        if (scnt_q == CNT_W'(1)) begin
                            state_d  = IDLE;
                            scnt_d   = '0;
                            hcnt_d   = '0;
                            sample_d = '0;
                            busy_d   = 1'b0;
                        end else begin
                            scnt_d = scnt_q - CNT_W'(1);
                            if (hcnt_q == HCNT_W'(1)) begin
                                hcnt_d   = per_q;
                                sample_d = -sample_q;
                            end else begin
                                hcnt_d = hcnt_q - HCNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!iRST_N) begin
            state_q  <= IDLE;
            scnt_q   <= '0;
            hcnt_q   <= '0;
            per_q    <= '0;
            sample_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            hcnt_q   <= hcnt_d;
            per_q    <= per_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
        end
    end

    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;
    assign busy                    = busy_q;

endmodule

// File: tb/tb_audio_click_scheduler.sv
// Directed bench with a reference timebase model and a click-sample scoreboard.
module tb_audio_click_scheduler;

    localparam int MOD = 60000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        allow;
    logic [8:0]  bpm_in;

    logic        wr, bp, busy;
    logic [1:0]  bi;
    logic [31:0] lch, rch;
    logic        wr2, bp2, busy2;
    logic [1:0]  bi2;
    logic [31:0] lch2, rch2;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    longint      m_acc;
    bit          m_first;
    int          m_idx;
    bit          m_beat;

    logic        o_beat, o_busy, o_busy2, o_wr;
    logic [1:0]  o_idx;
    logic [31:0] o_sample;

    always #5 clk = ~clk;

    audio_click_scheduler #(
        .CLK_HZ(1000), .SAMPLE_W(32), .CLICK_SAMPLES(8), .HALF_PER(2),
        .AMPLITUDE(32'd100), .BEATS_PER_BAR(4)
    ) dut (
        .CLOCK_50(clk), .iRST_N(rst_n), .enable(en), .bpm(bpm_in),
        .audio_out_allowed(allow), .write_audio_out(wr),
        .left_channel_audio_out(lch), .right_channel_audio_out(rch),
        .beat_pulse(bp), .beat_index(bi), .busy(busy)
    );

    audio_click_scheduler #(
        .CLK_HZ(1000), .SAMPLE_W(32), .CLICK_SAMPLES(300), .HALF_PER(2),
        .AMPLITUDE(32'd100), .BEATS_PER_BAR(4)
    ) dut2 (
        .CLOCK_50(clk), .iRST_N(rst_n), .enable(en), .bpm(bpm_in),
        .audio_out_allowed(allow), .write_audio_out(wr2),
        .left_channel_audio_out(lch2), .right_channel_audio_out(rch2),
        .beat_pulse(bp2), .beat_index(bi2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Expected burst: half-period 1 sample on accented beat 0, else 2 samples.
    task automatic push_burst(input int idx);
        int half;
        half = (idx == 0) ? 1 : 2;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back((((k / half) % 2) == 0) ? 32'd100 : -32'd100);
        end
    endtask

    task automatic model_update();
        int bc;
        bc = int'(bpm_in);
        if (bc < 30) bc = 30;
        else if (bc > 300) bc = 300;
        if (!rst_n || !en) begin
            m_acc = MOD - 1; m_first = 1'b1; m_idx = 0; m_beat = 1'b0;
        end else if (m_acc + bc >= MOD) begin
            m_beat = 1'b1;
            m_acc  = m_acc + bc - MOD;
            m_idx  = m_first ? 0 : (m_idx + 1) % 4;
            m_first = 1'b0;
        end else begin
            m_beat = 1'b0;
            m_acc  = m_acc + bc;
        end
    endtask

    // Observe mid-cycle, score writes, advance the model, then move past the next rising edge.
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        o_beat = bp; o_idx = bi; o_busy = busy; o_busy2 = busy2; o_wr = wr; o_sample = lch;
        check("write_strobe", 32'(wr), 32'(en & allow & rst_n));
        check("write_strobe2", 32'(wr2), 32'(en & allow & rst_n));
        check("right_eq_left", rch, lch);
        check("right_eq_left2", rch2, lch2);
        check("beat_pulse", 32'(bp), 32'(m_beat));
        check("beat_index", 32'(bi), 32'(m_idx));
        check("beat_pulse2", 32'(bp2), 32'(m_beat));
        check("beat_index2", 32'(bi2), 32'(m_idx));
        if (wr && busy) begin
            check("click_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("click_sample", lch, e);
            end
        end else if (wr) begin
            check("silence", lch, 32'd0);
        end
        model_update();
        if (m_beat) begin
            check("burst_done_before_beat", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            push_burst(m_idx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beat(input string tag, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!o_beat && n < budget);
        check({tag, "_seen"}, 32'(o_beat), 32'd1);
    endtask

    initial begin
        int n, bc, wc, drops;
        rst_n = 1'b0; en = 1'b0; allow = 1'b1; bpm_in = 9'd120;
        m_acc = MOD - 1; m_first = 1'b1; m_idx = 0; m_beat = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        check("reset_sample", o_sample, 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_busy2", 32'(o_busy2), 32'd0);
        rst_n = 1'b1;
        step();

        // Immediate beat on enable, then 500-cycle spacing at 120 bpm.
        en = 1'b1;
        wait_beat("first_beat", 8, n);
        check("first_beat_cycle", 32'(n - 1), 32'd1);
        check("first_beat_index", 32'(o_idx), 32'd0);
        step();
        check("arm_sample", o_sample, 32'd0);
        check("arm_busy", 32'(o_busy), 32'd0);
        step();
        check("click_latency_sample", o_sample, 32'd100);
        check("click_latency_busy", 32'(o_busy), 32'd1);
        wait_beat("beat1", 600, n);
        check("beat_gap1", 32'(n + 2), 32'd500);
        check("beat_index1", 32'(o_idx), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            wait_beat("beat_seq", 600, n);
            check("beat_gap", 32'(n), 32'd500);
            check("beat_index_seq", 32'(o_idx), 32'(k % 4));
        end

        // Throttled burst: allowed toggles, first click cycle not allowed.
        wait_beat("beat5", 600, n);
        check("beat_gap5", 32'(n), 32'd500);
        check("beat_index5", 32'(o_idx), 32'd1);
        step();
        bc = 0; wc = 0;
        for (int i = 0; i < 20; i++) begin
            allow = 1'((i % 2) == 1);
            step();
            if (o_busy) bc++;
            if (o_busy && o_wr) wc++;
        end
        allow = 1'b1;
        check("toggle_busy_cycles", 32'(bc), 32'd16);
        check("toggle_click_writes", 32'(wc), 32'd8);
        wait_beat("beat6", 600, n);
        check("beat_gap_after_toggle", 32'(n + 21), 32'd500);

        // Clamping: 10 -> 30 bpm, 400 -> 300 bpm.
        bpm_in = 9'd10;
        wait_beat("slow_first", 2200, n);
        wait_beat("slow", 2200, n);
        check("slow_gap", 32'(n), 32'd2000);
        bpm_in = 9'd400;
        wait_beat("fast_first", 300, n);
        wait_beat("fast", 300, n);
        check("fast_gap", 32'(n), 32'd200);

        // Reset while the fourth click sample is presented.
        wait_beat("pre_reset", 300, n);
        step(); step(); step(); step();
        rst_n = 1'b0;
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_sample", o_sample, 32'd0);
        check("post_reset_busy", 32'(o_busy), 32'd0);
        check("post_reset_beat", 32'(o_beat), 32'd0);
        check("post_reset_index", 32'(o_idx), 32'd0);
        wait_beat("post_reset_beat", 4, n);
        check("post_reset_beat_cycle", 32'(n), 32'd1);
        check("post_reset_beat_index", 32'(o_idx), 32'd0);
        repeat (20) step();
        check("drained", 32'(exp_q.size()), 32'd0);

        // Long bursts at 300 bpm restart on every beat and never idle.
        bpm_in = 9'd300;
        en = 1'b0;
        step();
        en = 1'b1;
        wait_beat("restart_beat", 4, n);
        step();
        step();
        check("dut2_busy_start", 32'(o_busy2), 32'd1);
        drops = 0;
        repeat (900) begin
            step();
            if (!o_busy2) drops++;
        end
        check("dut2_busy_drops", 32'(drops), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
